direct_cache_ctrl: RTL
======================

DIRECT_CACHE_CTRL -- requirements
Module: direct_cache_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32: bits per cache word and per memory word.
REQ-002 Parameter ADDR_WIDTH, default 32: byte-address width.
REQ-003 Parameter C, default 3: log2 of the number of lines; 2**C one-word lines.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; the block is in reset while reset=0.
REQ-006 cpu_req  input  1  CPU request strobe, sampled in IDLE only.
REQ-007 cpu_we  input  1  1 = write request, 0 = read request.
REQ-008 cpu_addr  input  ADDR_WIDTH  byte address; bits [1:0] ignored.
REQ-009 cpu_wdata  input  DATA_WIDTH  write data.
REQ-010 cpu_ready  output  1  one-cycle pulse marking completion of the accepted request.
REQ-011 cpu_rdata  output  DATA_WIDTH  read data, valid while cpu_ready=1.
REQ-012 flush  input  1  invalidate all lines.
REQ-013 mem_req  output  1  backing-memory request, held until mem_ack.
REQ-014 mem_we  output  1  backing-memory write enable, stable while mem_req=1.
REQ-015 mem_addr  output  ADDR_WIDTH  word-aligned memory address ([1:0]=0), stable while mem_req=1.
REQ-016 mem_wdata  output  DATA_WIDTH  memory write data, stable while mem_req=1.
REQ-017 mem_ack  input  1  memory completion; sampled only while mem_req=1.
REQ-018 mem_rdata  input  DATA_WIDTH  read data, valid in the same cycle as mem_ack.
REQ-019 hit_count, miss_count  outputs  16 each  saturating lookup statistics.

Function
REQ-020 Storage: internal array of 2**C entries, each holding a valid bit, a tag of ADDR_WIDTH-C-2 bits, and one data word.
REQ-021 Address fields: index = addr[C+1:2]; tag = addr[ADDR_WIDTH-1:C+2]; hit = valid[index] and (stored tag equals tag).
REQ-022 States: IDLE, FILL, WTHRU, RESP; encoding is free.
REQ-023 IDLE, flush=1: clear all valid bits at the next edge and remain in IDLE; flush has priority over cpu_req.
REQ-024 IDLE, cpu_req=1, cpu_we=0: latch addr; on a hit, register line data into cpu_rdata and go to RESP, else go to FILL.
REQ-025 IDLE, cpu_req=1, cpu_we=1: latch addr and wdata and go to WTHRU.
REQ-026 FILL: mem_req=1, mem_we=0, mem_addr={latched addr[ADDR_WIDTH-1:2],2'b00}.
REQ-027 FILL, on mem_ack: write {valid=1, tag, mem_rdata} into the line, register mem_rdata into cpu_rdata, go to RESP.
REQ-028 WTHRU (write-through, no write-allocate): mem_req=1, mem_we=1, mem_wdata=latched wdata.
REQ-029 WTHRU, on mem_ack: if the line hits, update its data; a missing line is left unchanged; go to RESP.
REQ-030 RESP: cpu_ready=1 for exactly one cycle, then IDLE; cpu_req is ignored in RESP.
REQ-031 Latency: read hit cpu_ready 2 cycles after the cpu_req sample edge; a miss or write adds 1 cycle per memory wait cycle plus 1.
REQ-032 mem_req is deasserted in the cycle after mem_ack; there are no back-to-back memory requests without passing through RESP.
REQ-033 flush outside IDLE is ignored; it is not queued.
REQ-034 hit_count increments on each read hit and each write hit, evaluated at acceptance; miss_count increments on each read miss and write miss; both saturate at 16'hFFFF.
REQ-035 cpu_rdata holds its last value outside RESP; writes leave cpu_rdata unchanged.

Reset
REQ-036 While reset=0: state=IDLE, all valid bits=0, cpu_ready=0, cpu_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, hit_count=0, miss_count=0.
REQ-037 Reset during FILL or WTHRU abandons the transaction: mem_req drops immediately and no line is written; a late mem_ack after reset is ignored.
REQ-038 Data and tag arrays need no reset; only the valid bits are cleared.

Verification
REQ-039 Read 0x0000_0010 after reset, memory returns 0xDEAD_BEEF after 3 wait cycles -> mem_req with mem_addr=0x10, cpu_ready with 0xDEAD_BEEF, miss_count=1.
REQ-040 Repeat the read of 0x10 -> no mem_req, cpu_ready 2 cycles after the request with 0xDEAD_BEEF, hit_count=1.
REQ-041 Write 0x1234_5678 to 0x10, then read 0x10 -> mem_we=1 write-through with mem_wdata=0x1234_5678; the read hits and returns 0x1234_5678.
REQ-042 Read 0x30 (same index 4, different tag) -> miss and refill; a subsequent read of 0x10 misses again.
REQ-043 flush with cpu_req in the same cycle -> all lines invalid, the request is not accepted, and the next read of 0x30 misses.
REQ-044 Assert reset mid-FILL, then pulse mem_ack -> mem_req=0 immediately, no cpu_ready, and the line stays invalid.

Source files
------------

// File: rtl/direct_cache_ctrl_if.sv
// CPU-side and memory-side bundle of the direct-mapped cache controller.
// The master modport is the cache controller; the slave modport is its environment.
interface direct_cache_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  cpu_ready;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  flush;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, flush,
        input  mem_ack, mem_rdata,
        output cpu_ready, cpu_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, flush,
        output mem_ack, mem_rdata,
        input  cpu_ready, cpu_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/direct_cache_ctrl.sv
// Direct-mapped, one-word-per-line, write-through / no-write-allocate cache
// controller with saturating hit and miss statistics.
module direct_cache_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int C          = 3
) (
    input  logic                clk,
    input  logic                reset,
    direct_cache_ctrl_if.master bus,
    output logic [15:0]         hit_count,
    output logic [15:0]         miss_count
);
    localparam int LINES = 2 ** C;
    localparam int TW    = ADDR_WIDTH - C - 2;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WTHRU,
        RESP
    } state_t;

    state_t state, state_n;

    logic [ADDR_WIDTH-3:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  mem_req_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic [15:0]           hit_q;
    logic [15:0]           miss_q;

    logic [LINES-1:0]      valid_q;
    logic [TW-1:0]         tag_q  [LINES];
    logic [DATA_WIDTH-1:0] data_q [LINES];

    logic [C-1:0]          req_idx;
    logic [TW-1:0]         req_tag;
    logic                  req_hit;
    logic [C-1:0]          lat_idx;
    logic [TW-1:0]         lat_tag;
    logic                  lat_hit;

    logic                  accept;
    logic                  do_flush;
    logic                  ack;
    logic                  fill_wr;
    logic                  wthru_wr;
    logic                  need_mem;
    logic                  unused_bits;

    assign req_idx = bus.cpu_addr[C+1:2];
    assign req_tag = bus.cpu_addr[ADDR_WIDTH-1:C+2];
    assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    assign lat_idx = waddr_q[C-1:0];
    assign lat_tag = waddr_q[ADDR_WIDTH-3:C];
    assign lat_hit = valid_q[lat_idx] && (tag_q[lat_idx] == lat_tag);

    // Byte offset within the word carries no meaning for a word cache.
    assign unused_bits = ^bus.cpu_addr[1:0];

    assign need_mem = bus.cpu_we || !req_hit;
    assign fill_wr  = ack && (state == FILL);
    assign wthru_wr = ack && (state == WTHRU) && lat_hit;

    assign bus.cpu_ready = (state == RESP);
    assign bus.cpu_rdata = rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign hit_count     = hit_q;
    assign miss_count    = miss_q;

    // Controller state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state plus the one-cycle events that steer the datapath.
    always_comb begin
        state_n  = state;
        accept   = 1'b0;
        do_flush = 1'b0;
        ack      = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.flush) begin
                    do_flush = 1'b1;
                end else if (bus.cpu_req) begin
                    accept = 1'b1;
                    if (bus.cpu_we) begin
                        state_n = WTHRU;
                    end else if (req_hit) begin
                        state_n = RESP;
                    end else begin
                        state_n = FILL;
                    end
                end
            end
            FILL, WTHRU: begin
                if (bus.mem_ack) begin
                    ack     = 1'b1;
                    state_n = RESP;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Latched request fields used while the memory transaction runs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            waddr_q <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            waddr_q <= bus.cpu_addr[ADDR_WIDTH-1:2];
            if (bus.cpu_we) begin
                wdata_q <= bus.cpu_wdata;
            end
        end
    end

    // Read data returned to the CPU; untouched by writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else if (accept && !bus.cpu_we && req_hit) begin
            rdata_q <= data_q[req_idx];
        end else if (fill_wr) begin
            rdata_q <= bus.mem_rdata;
        end
    end

    // Memory request, held stable from acceptance until the ack edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else if (accept && need_mem) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= bus.cpu_we;
            mem_addr_q <= {bus.cpu_addr[ADDR_WIDTH-1:2], 2'b00};
            if (bus.cpu_we) begin
                mem_wdata_q <= bus.cpu_wdata;
            end
        end else if (ack) begin
            mem_req_q <= 1'b0;
        end
    end

    // Valid bits: bulk clear on flush, set on a completed refill.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else if (do_flush) begin
            valid_q <= '0;
        end else if (fill_wr) begin
            valid_q[lat_idx] <= 1'b1;
        end
    end

    // Tag and data storage; contents are meaningless until valid is set.
    always_ff @(posedge clk) begin
        if (fill_wr) begin
            tag_q[lat_idx]  <= lat_tag;
            data_q[lat_idx] <= bus.mem_rdata;
        end else if (wthru_wr) begin
            data_q[lat_idx] <= wdata_q;
        end
    end

    // Saturating lookup statistics, classified at acceptance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (accept) begin
            if (req_hit) begin
                if (hit_q != 16'hFFFF) begin
                    hit_q <= hit_q + 16'd1;
                end
            end else begin
                if (miss_q != 16'hFFFF) begin
                    miss_q <= miss_q + 16'd1;
                end
            end
        end
    end
endmodule
